// File: rtl/lite16_pkg.sv
// Shared definitions for the two-read/one-write register file.
// Holds the default geometry and the encoding of the clear-sweep FSM.
package lite16_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_REG_COUNT  = 16;

  // Clear-sweep FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
// Selects register[raddr] with the same-cycle forwarding rules applied,
// and captures it into the output register when re is high.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   re, raddr               read enable and address
//   regs                    current contents of every register
//   wr_accept/waddr/wdata   the write that will land at this clock edge
//   clearing, sweep_idx     the register the clear sweep zeroes at this edge
//   rdata                   registered read data (holds while re=0)
module regfile_read_port
  import lite16_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int ZERO_REG   = 0,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  re,
  input  logic [ADDR_WIDTH-1:0]                 raddr,
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs,
  input  logic                                  wr_accept,
  input  logic [ADDR_WIDTH-1:0]                 waddr,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  input  logic                                  clearing,
  input  logic [ADDR_WIDTH-1:0]                 sweep_idx,
  output logic [DATA_WIDTH-1:0]                 rdata
);

  logic                  in_range;
  logic [DATA_WIDTH-1:0] read_value;
  logic [DATA_WIDTH-1:0] rdata_reg;

  assign in_range = int'(raddr) < REG_COUNT;

  // Priority: invalid address, then hardwired zero, then the register the
  // sweep is clearing this cycle, then a same-cycle write, then storage.
  // A write and the sweep never coincide because writes are refused while
  // clearing.
  always_comb begin
    read_value = '0;
    if (!in_range) begin
      read_value = '0;
    end else if (ZERO_REG != 0 && raddr == '0) begin
      read_value = '0;
    end else if (clearing && raddr == sweep_idx) begin
      read_value = '0;
    end else if (wr_accept && waddr == raddr) begin
      read_value = wdata;
    end else begin
      read_value = regs[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= read_value;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/regfile_2r1w.sv
// Flop-based register file with two registered read ports, one write port
// and a background clear sweep that zeroes one register per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we, waddr, wdata    write port (ignored while busy)
//   re_a, raddr_a       read port A request; rdata_a valid next cycle
//   re_b, raddr_b       read port B request; rdata_b valid next cycle
//   clr_req             one-cycle request to start the clear sweep
//   busy                high for the REG_COUNT cycles of the sweep
module regfile_2r1w
  import lite16_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter  int ZERO_REG   = 0,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clr_req,
  output logic                  busy
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] sweep_idx_reg, sweep_idx_next;
  logic                  clearing;
  logic                  last_idx;
  logic                  waddr_ok;
  logic                  wr_accept;

  assign clearing = (state_reg == ST_CLEAR);
  assign busy     = clearing;
  assign last_idx = (sweep_idx_reg == ADDR_WIDTH'(REG_COUNT - 1));

  // Writes are refused during the sweep, outside the file, and to the
  // hardwired zero register.
  assign waddr_ok  = int'(waddr) < REG_COUNT;
  assign wr_accept = we && !clearing && waddr_ok &&
                     !(ZERO_REG != 0 && waddr == '0);

  // Clear-sweep FSM. A clr_req seen in CLEAR is simply not looked at.
  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        sweep_idx_next = '0;
        if (clr_req) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (last_idx) begin
          state_next     = ST_IDLE;
          sweep_idx_next = '0;
        end else begin
          sweep_idx_next = sweep_idx_reg + 1'b1;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        sweep_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  // Storage: one flop bank per register with its own write/clear decode.
  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_flop
        logic                  clr_hit;
        logic                  wr_hit;
        logic [DATA_WIDTH-1:0] q_reg;

        assign clr_hit = clearing && (sweep_idx_reg == ADDR_WIDTH'(gi));
        assign wr_hit  = wr_accept && (waddr == ADDR_WIDTH'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (clr_hit) begin
            q_reg <= '0;
          end else if (wr_hit) begin
            q_reg <= wdata;
          end
        end

        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ZERO_REG   (ZERO_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .re        (re_a),
    .raddr     (raddr_a),
    .regs      (regs),
    .wr_accept (wr_accept),
    .waddr     (waddr),
    .wdata     (wdata),
    .clearing  (clearing),
    .sweep_idx (sweep_idx_reg),
    .rdata     (rdata_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ZERO_REG   (ZERO_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .re        (re_b),
    .raddr     (raddr_b),
    .regs      (regs),
    .wr_accept (wr_accept),
    .waddr     (waddr),
    .wdata     (wdata),
    .clearing  (clearing),
    .sweep_idx (sweep_idx_reg),
    .rdata     (rdata_b)
  );

endmodule
